seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for a bank of common-cathode 7-segment digits sharing one BCD-to-segment decoder.
//  Latches a multi-digit BCD word and presents one digit at a time to the decoder.
//  Drives the active-low digit select, with a blanking dead time between slots to suppress ghosting.
//  Sits between the counter/datapath that produces BCD values and the shared segment decoder.
// PARAMETERS
//  NUM_DIGITS  4      number of multiplexed digits (2..8)
//  PRESCALE    50000  clk cycles per digit slot (>= DEAD+2)
//  DEAD        16     clk cycles at start of each slot with all digits off (>= 1)
// PORTS
//  clk         in   1             system clock, rising edge
//  rst_n       in   1             asynchronous active-low reset
//  en          in   1             scan enable; 0 = display dark, counters held
//  load        in   1             1-cycle strobe: capture din
//  din         in   4*NUM_DIGITS  BCD digits, [3:0] = digit 0 (least significant)
//  data        out  4             BCD code to the shared decoder
//  sel         out  NUM_DIGITS    digit select, active low, at most one bit 0
//  frame_done  out  1             1-cycle pulse at the end of the last slot of each frame
// BEHAVIOUR
//  Reset: data=0, sel=all 1, frame_done=0, active and pending words=0, pending flag=0, counters=0, state IDLE.
//  Counters: tick 0..PRESCALE-1; on wrap, idx advances 0..NUM_DIGITS-1 and wraps to 0.
//  States:
//   - IDLE: en=0; sel=all 1; counters forced to 0.
//   - IDLE->BLANK when en=1.
//   - BLANK: tick<DEAD; sel=all 1; data=active[idx].
//   - BLANK->SHOW when tick=DEAD-1.
//   - SHOW: sel[idx]=0.
//   - SHOW->BLANK on tick wrap.
//   - Any state->IDLE when en=0 (next cycle).
//  Outputs are registered: data, sel and frame_done reflect the tick/idx/state of the previous cycle (1-cycle latency).
//  Tear-free update:
//   - load copies din into pending and sets the pending flag.
//   - At the frame boundary (idx=NUM_DIGITS-1 and tick wrap), pending moves to active and the flag clears.
//   - load on the boundary cycle: din goes directly to active.
//   - Repeated loads before a boundary: the last load wins.
//   - While en=0, a pending word transfers to active on the cycle en rises.
//  Invalid code: active digit >9 keeps its sel bit at 1 for the whole slot; data is forced to 0.
//  frame_done: asserted one cycle after the boundary, only while en=1.
//  en dropped mid-slot: sel=all 1 from the next cycle; restart is at idx 0, tick 0; pending is kept.
//  Async reset mid-frame clears everything immediately, including pending.
// CONFIGURATION
//  SEG_LZB_EN defined: leading-zero blanking.
//   - Digits above the most significant nonzero digit that hold 0 keep sel=1 for their slot.
//   - Digit 0 is always shown.
//   - The blank mask is computed from active at transfer time and registered.
//  SEG_LZB_EN undefined: every digit 0..9 is displayed; no mask logic.
// STRUCTURE
//  Package seg_pkg:
//   - state typedef {IDLE, BLANK, SHOW}
//   - BCD_MAX=4'd9
//   - SEL_OFF function returning all-ones of width NUM_DIGITS
//  Sub-module seg_prescaler: tick counter with wrap pulse and synchronous clear; parameter PRESCALE.
//  Top: FSM, idx counter, pending/active registers, output registers, optional LZB mask.
// TESTING
//  (PRESCALE=8, DEAD=2, NUM_DIGITS=4 for all)
//  1. Reset, then en=1, load din=16'h1234.
//     -> from the next frame, the per-slot sequence is data=4,3,2,1 with sel=1110,1101,1011,0111.
//     -> each slot shows 2 cycles of sel=1111, then 6 cycles active.
//  2. Mid-frame load 16'h5678.
//     -> the current frame still shows 1234.
//     -> 5678 appears from idx 0 after frame_done.
//     -> frame_done is exactly 1 cycle wide, every 32 cycles.
//  3. Load din=16'h12A4.
//     -> slot 1 has sel=1111 throughout and data=0.
//     -> other digits are unaffected.
//  4. Drop en at idx=2, tick=5.
//     -> sel=1111 next cycle; no frame_done.
//     -> after re-raising en, the scan restarts at idx 0 following a 2-cycle blank.
//  5. Assert rst_n=0 mid-SHOW with a pending load.
//     -> outputs reset asynchronously.
//     -> after release, active=0 is displayed and the pending word is lost.
//  6. With SEG_LZB_EN, din=16'h0070.
//     -> slots 3 and 2 stay blank; slot 1 shows 7, slot 0 shows 0.
//  6b. With SEG_LZB_EN, din=16'h0000.
//     -> only slot 0 is lit.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Used by seg_scan_ctrl and seg_prescaler.
package seg_pkg;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // All-ones digit-select pattern for n digits (n <= 8), upper bits zero.
  function automatic logic [7:0] SEL_OFF(input int n);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/seg_prescaler.sv
// Slot tick counter: counts 0..PRESCALE-1, flags the last count with wrap,
// and returns to 0 whenever clr is asserted.
module seg_prescaler #(
  parameter int PRESCALE = 50000,
  parameter int TW       = $clog2(PRESCALE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  output logic [TW-1:0] tick,
  output logic          wrap
);

  logic [TW-1:0] tick_reg;

  assign wrap = !clr && (tick_reg == TW'(PRESCALE - 1));
  assign tick = tick_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_reg <= '0;
    end else if (clr || wrap) begin
      tick_reg <= '0;
    end else begin
      tick_reg <= tick_reg + 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for common-cathode 7-segment digits.
// Optional leading-zero blanking is built when SEG_LZB_EN is defined.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000,
  parameter int DEAD       = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] din,
  output logic [3:0]              data,
  output logic [NUM_DIGITS-1:0]   sel,
  output logic                    frame_done
);

  localparam int DW    = 4 * NUM_DIGITS;
  localparam int TW    = $clog2(PRESCALE);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [7:0]            SEL_ALL  = SEL_OFF(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] ALL_OFF  = SEL_ALL[NUM_DIGITS-1:0];

  state_t                state_reg, state_next;
  logic [IDX_W-1:0]      idx_reg, idx_next;
  logic [DW-1:0]         active_reg, active_next;
  logic [DW-1:0]         pending_reg, pending_next;
  logic                  pend_flag_reg, pend_flag_next;
  logic [3:0]            data_reg, data_next;
  logic [NUM_DIGITS-1:0] sel_reg, sel_next;
  logic                  frame_done_reg, frame_done_next;
  logic [NUM_DIGITS-1:0] blank_mask;

  logic [TW-1:0] tick;
  logic          wrap;
  logic          clr;
  logic          boundary;
  logic          xfer;
  logic [3:0]    cur_digit;
  logic          invalid;

  // Counters only run while scanning; leaving IDLE always starts at tick 0.
  assign clr = (state_reg == IDLE) || !en;

  seg_prescaler #(
    .PRESCALE (PRESCALE),
    .TW       (TW)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .tick  (tick),
    .wrap  (wrap)
  );

  assign boundary  = wrap && (idx_reg == IDX_LAST);
  assign xfer      = boundary || ((state_reg == IDLE) && en);
  assign cur_digit = active_reg[{idx_reg, 2'b00} +: 4];
  assign invalid   = (cur_digit > BCD_MAX);

  always_comb begin
    state_next = state_reg;
    if (!en) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    state_next = BLANK;
        BLANK:   if (tick == TW'(DEAD - 1)) state_next = SHOW;
        SHOW:    if (wrap) state_next = BLANK;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    idx_next = idx_reg;
    if (clr) begin
      idx_next = '0;
    end else if (wrap) begin
      idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
    end
  end

  // Words only reach the display at a frame boundary (or on scan start),
  // so a frame never mixes digits from two different loads.
  always_comb begin
    active_next    = active_reg;
    pending_next   = pending_reg;
    pend_flag_next = pend_flag_reg;
    if (xfer) begin
      if (load) begin
        active_next = din;
      end else if (pend_flag_reg) begin
        active_next = pending_reg;
      end
      pend_flag_next = 1'b0;
    end else if (load) begin
      pending_next   = din;
      pend_flag_next = 1'b1;
    end
  end

  always_comb begin
    data_next       = invalid ? 4'd0 : cur_digit;
    sel_next        = ALL_OFF;
    frame_done_next = boundary;
    if (en && (state_reg == SHOW) && !invalid && !blank_mask[idx_reg]) begin
      sel_next[idx_reg] = 1'b0;
    end
  end

`ifdef SEG_LZB_EN
  logic [NUM_DIGITS-1:0] lzb_next, blank_mask_reg;

  // A digit is blanked when it and every digit above it are zero.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lzb
      if (gi == 0) begin : g_lsd
        assign lzb_next[gi] = 1'b0;
      end else begin : g_upper
        assign lzb_next[gi] = (active_next[DW-1:4*gi] == '0);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_mask_reg <= {ALL_OFF[NUM_DIGITS-1:1], 1'b0};
    end else if (xfer) begin
      blank_mask_reg <= lzb_next;
    end
  end

  assign blank_mask = blank_mask_reg;
`else
  assign blank_mask = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      active_reg     <= '0;
      pending_reg    <= '0;
      pend_flag_reg  <= 1'b0;
      data_reg       <= 4'd0;
      sel_reg        <= ALL_OFF;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      active_reg     <= active_next;
      pending_reg    <= pending_next;
      pend_flag_reg  <= pend_flag_next;
      data_reg       <= data_next;
      sel_reg        <= sel_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign data       = data_reg;
  assign sel        = sel_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (NUM_DIGITS=4, PRESCALE=8, DEAD=2) with an
// expected-output queue filled per frame and drained one entry per clock.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] din = 16'h0000;
  logic [3:0]  data;
  logic [3:0]  sel;
  logic        frame_done;

  int n_assert = 0;
  int n_fail   = 0;
  int n_cycle  = 0;

  logic [8:0] exp_q[$];

  seg_scan_ctrl #(
    .NUM_DIGITS (4),
    .PRESCALE   (8),
    .DEAD       (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .din        (din),
    .data       (data),
    .sel        (sel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [3:0] d, input logic [3:0] s, input logic f);
    exp_q.push_back({d, s, f});
  endtask

  // Expected outputs for one frame of word w: per slot 2 dark cycles then 6 lit,
  // frame_done on the very last sample. Only the first cnt entries are queued.
  task automatic push_frame(input logic [15:0] w, input int cnt);
    int k;
    k = 0;
    for (int d = 0; d < 4; d++) begin
      logic [3:0] dig;
      logic [3:0] on_sel;
      logic       valid;
      logic       blank;
      dig       = w[4*d +: 4];
      valid     = (dig <= 4'd9);
      blank     = 1'b0;
`ifdef SEG_LZB_EN
      blank     = (d > 0) && ((w >> (4*d)) == 16'h0000);
`endif
      on_sel    = 4'hF;
      on_sel[d] = 1'b0;
      for (int s = 0; s < 8; s++) begin
        if (k < cnt) begin
          push(valid ? dig : 4'd0,
               (s >= 2 && valid && !blank) ? on_sel : 4'hF,
               (d == 3) && (s == 7));
        end
        k++;
      end
    end
  endtask

  task automatic cycle(input int n);
    logic [8:0] obs;
    logic [8:0] e;
    repeat (n) begin
      @(posedge clk);
      #1;
      load = 1'b0;
      n_cycle++;
      if (exp_q.size() > 0) begin
        obs = {data, sel, frame_done};
        e   = exp_q.pop_front();
        n_assert++;
        assert (obs === e) else begin
          n_fail++;
          $error("FAIL scan cyc=%0d data/sel/fd obs=%h/%b/%b exp=%h/%b/%b",
                 n_cycle, obs[8:5], obs[4:1], obs[0], e[8:5], e[4:1], e[0]);
        end
      end
    end
  endtask

  task automatic check_reset(input string tag);
    n_assert++;
    assert (data === 4'd0) else begin
      n_fail++;
      $error("FAIL %s_data obs=%h exp=0", tag, data);
    end
    n_assert++;
    assert (sel === 4'hF) else begin
      n_fail++;
      $error("FAIL %s_sel obs=%b exp=1111", tag, sel);
    end
    n_assert++;
    assert (frame_done === 1'b0) else begin
      n_fail++;
      $error("FAIL %s_fd obs=%b exp=0", tag, frame_done);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    $display("step reset: outputs checked");

    // 1: enable, then load 1234 into pending; first frame shows 0000
    rst_n = 1'b1;
    en    = 1'b1;
    push(4'd0, 4'hF, 1'b0);
    cycle(1);
    load = 1'b1;
    din  = 16'h1234;
    push_frame(16'h0000, 32);
    push_frame(16'h1234, 32);
    cycle(40);
    $display("step 1: load 1234, frame 0000 then 1234");

    // 2: mid-frame load 5678, current frame keeps 1234
    load = 1'b1;
    din  = 16'h5678;
    push_frame(16'h5678, 32);
    cycle(56);
    $display("step 2: mid-frame load 5678");

    // 3: invalid digit A in slot 1
    load = 1'b1;
    din  = 16'h12A4;
    push_frame(16'h5678, 32);
    push_frame(16'h12A4, 32);
    cycle(64);
    $display("step 3: load 12A4 with invalid digit");

    // 4: drop en at idx 2 tick 5, load while idle, restart on en rise
    push_frame(16'h12A4, 21);
    cycle(21);
    en = 1'b0;
    push(4'd2, 4'hF, 1'b0);
    cycle(1);
    push(4'd4, 4'hF, 1'b0);
    cycle(1);
    load = 1'b1;
    din  = 16'h1234;
    push(4'd4, 4'hF, 1'b0);
    cycle(1);
    push(4'd4, 4'hF, 1'b0);
    cycle(1);
    en = 1'b1;
    push(4'd4, 4'hF, 1'b0);
    push_frame(16'h1234, 32);
    cycle(33);
    $display("step 4: en drop mid-slot and restart");

    // 5: async reset mid-SHOW with a pending load
    push_frame(16'h1234, 13);
    cycle(12);
    load = 1'b1;
    din  = 16'h5678;
    cycle(1);
    rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(4'd0, 4'hF, 1'b0);
    push_frame(16'h0000, 32);
    push_frame(16'h0000, 32);
    cycle(65);
    $display("step 5: async reset drops pending word");

    // 6: leading-zero patterns 0070 and 0000
    load = 1'b1;
    din  = 16'h0070;
    push_frame(16'h0000, 32);
    push_frame(16'h0070, 32);
    cycle(64);
    load = 1'b1;
    din  = 16'h0000;
    push_frame(16'h0070, 32);
    push_frame(16'h0000, 32);
    cycle(64);
    $display("step 6: words 0070 and 0000");

    n_assert++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL queue_drain obs=%0d exp=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
